candy_ctrl: RTL and testbench
=============================

Name: candy_ctrl

Overview:
- Multi-cycle control sequencer for the candy core; sits directly upstream of the pc, if, id, alu, load and wb stages.
- Generates their enable strobes in order: fetch, decode, dispatch, execute/load/store, PC advance.
- Waits on the fetch and store handshakes, bounds each wait with a timeout.
- Tracks retired instructions and reports halt and fault status to the top level.

Parameters:
- OP_W, 4, width of the decoded opcode from candy_id.
- TIMEOUT, 16, maximum cycles spent waiting in FETCH or STORE before faulting (>=2).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  core clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin execution from IDLE; ignored in every other state.
- if_ready  in  1  fetched instruction valid (candy_if data_ready).
- op  in  OP_W  decoded opcode, valid in the DISPATCH cycle.
- wb_done  in  1  SRAM store accepted by candy_wb.
- pc_enable  out  1  one-cycle PC advance strobe.
- if_enable  out  1  fetch request, held through FETCH.
- id_enable  out  1  one-cycle decode strobe.
- alu_enable  out  1  one-cycle execute strobe.
- reg_we  out  1  one-cycle register-file write strobe for ALU results.
- load_enable  out  1  one-cycle load-immediate strobe.
- wb_enable  out  1  store request, held through STORE.
- halted  out  1  core stopped by HALT opcode.
- fault  out  1  core stopped by error.
- fault_code  out  2  01 = fetch timeout, 10 = store timeout, 11 = illegal opcode, 00 = none.
- instret  out  CNT_W  retired-instruction count.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, DISPATCH=3, EXEC=4, WRITEBACK=5, LOAD=6, STORE=7, NEXT=8, HALT=9, FAULT=10.
- Reset: on any edge with rst=1, from any state including mid-wait:
  - state goes to IDLE.
  - instret, timeout counter and fault_code clear to 0.
  - all strobes, halted and fault are 0.
- Outputs are Moore, decoded from the state register only; no input-to-output combinational path.
- IDLE: all strobes 0. start=1 -> FETCH.
- FETCH: if_enable=1.
  - if_ready=1 -> DECODE.
  - Otherwise the timeout counter increments.
  - Counter reaching TIMEOUT-1 with if_ready=0 -> FAULT, fault_code=01.
  - if_ready has priority over timeout in the same cycle.
- DECODE: id_enable=1 for one cycle -> DISPATCH.
- DISPATCH: op is sampled and the next state is chosen:
  - op 0 (NOP) -> NEXT.
  - op 1..7 (ALU class) -> EXEC.
  - op 8 (LOADI) -> LOAD.
  - op 9 (STORE) -> STORE.
  - op 15 (HALT) -> HALT.
  - op 10..14 -> FAULT, fault_code=11.
- EXEC: alu_enable=1 -> WRITEBACK.
- WRITEBACK: reg_we=1 -> NEXT.
- LOAD: load_enable=1 -> NEXT.
- STORE: wb_enable=1.
  - wb_done=1 -> NEXT.
  - Timeout uses the same rules as FETCH; expiry -> FAULT, fault_code=10.
- NEXT: pc_enable=1 and instret increments (wraps modulo 2^CNT_W) -> FETCH.
- Timeout counter: clears on every entry to FETCH or STORE; width clog2(TIMEOUT).
- HALT: halted=1, instret frozen, HALT is not counted. Only rst exits.
- FAULT: fault=1, fault_code held, instret frozen. Only rst exits.
- Exactly one of pc_enable, id_enable, alu_enable, reg_we, load_enable is high in any cycle, or none.
- if_enable and wb_enable are never high together.
- Latency per instruction, with ready/done arriving in the first wait cycle:
  - NOP: 4 cycles.
  - LOADI: 5 cycles.
  - ALU: 6 cycles.
  - STORE: 5 cycles.
  - Each extra wait cycle adds 1.

Test Plan:
- Reset then start at cycle 0; if_ready high on first FETCH cycle; op=3 -> state_o sequence 1,2,3,4,5,8,1; reg_we high exactly 1 cycle; instret=1 after NEXT.
- Program NOP, LOADI(8), STORE(9) with wb_done delayed 3 cycles, then HALT(15) -> instret=3, halted=1; pc_enable pulsed 3 times; wb_enable high 4 cycles.
- if_ready never asserted, TIMEOUT=16 -> fault=1, fault_code=01 after exactly 16 FETCH cycles; if_ready on the 16th cycle instead -> DECODE, no fault.
- op=12 at DISPATCH -> FAULT, fault_code=11; start pulses afterwards ignored; all strobes 0.
- rst asserted during STORE with wb_enable=1 -> next edge state_o=0, wb_enable=0, instret=0; start restarts in FETCH.
- CNT_W=4, 16 NOPs -> instret wraps 15 -> 0; start asserted mid-run has no effect.

Source files
------------

// File: rtl/candy_ctrl.sv
// Multi-cycle control sequencer for the candy core: strobes fetch, decode,
// dispatch, execute/load/store and PC advance, with bounded handshake waits.
module candy_ctrl #(
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             if_ready,
  input  logic [OP_W-1:0]  op,
  input  logic             wb_done,
  output logic             pc_enable,
  output logic             if_enable,
  output logic             id_enable,
  output logic             alu_enable,
  output logic             reg_we,
  output logic             load_enable,
  output logic             wb_enable,
  output logic             halted,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    DISPATCH  = 4'd3,
    EXEC      = 4'd4,
    WRITEBACK = 4'd5,
    LOAD      = 4'd6,
    STORE     = 4'd7,
    NEXT      = 4'd8,
    HALT      = 4'd9,
    FAULT     = 4'd10
  } state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] tcnt;
  logic [1:0]      fc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      instret    <= '0;
      fault_code <= 2'b00;
    end else begin
      state <= state_next;
      // Any state change restarts the wait budget for the next FETCH/STORE.
      if (state_next != state)
        tcnt <= '0;
      else if (state == FETCH || state == STORE)
        tcnt <= tcnt + TO_W'(1);
      if (state == NEXT)
        instret <= instret + CNT_W'(1);
      if (state_next == FAULT && state != FAULT)
        fault_code <= fc_next;
    end
  end

  always_comb begin
    state_next = state;
    fc_next    = 2'b00;
    case (state)
      IDLE:      if (start) state_next = FETCH;
      FETCH: begin
        if (if_ready) state_next = DECODE;
        else if (tcnt == TO_LAST) begin
          state_next = FAULT;
          fc_next    = 2'b01;
        end
      end
      DECODE:    state_next = DISPATCH;
      DISPATCH: begin
        if (op == OP_W'(0))       state_next = NEXT;
        else if (op <= OP_W'(7))  state_next = EXEC;
        else if (op == OP_W'(8))  state_next = LOAD;
        else if (op == OP_W'(9))  state_next = STORE;
        else if (op == OP_W'(15)) state_next = HALT;
        else begin
          state_next = FAULT;
          fc_next    = 2'b11;
        end
      end
      EXEC:      state_next = WRITEBACK;
      WRITEBACK: state_next = NEXT;
      LOAD:      state_next = NEXT;
      STORE: begin
        if (wb_done) state_next = NEXT;
        else if (tcnt == TO_LAST) begin
          state_next = FAULT;
          fc_next    = 2'b10;
        end
      end
      NEXT:      state_next = FETCH;
      HALT:      state_next = HALT;
      FAULT:     state_next = FAULT;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_enable   = (state == NEXT);
    if_enable   = (state == FETCH);
    id_enable   = (state == DECODE);
    alu_enable  = (state == EXEC);
    reg_we      = (state == WRITEBACK);
    load_enable = (state == LOAD);
    wb_enable   = (state == STORE);
    halted      = (state == HALT);
    fault       = (state == FAULT);
    state_o     = state;
  end

endmodule

// File: tb/tb_candy_ctrl.sv
// Directed bench for candy_ctrl: vector table for the main program flow, plus
// hand sequences for timeouts, illegal opcode, mid-wait reset and counter wrap.
module tb_candy_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, if_ready, wb_done;
  logic [3:0]  op;

  logic        pc_enable, if_enable, id_enable, alu_enable, reg_we;
  logic        load_enable, wb_enable, halted, fault;
  logic [1:0]  fault_code;
  logic [31:0] instret;
  logic [3:0]  state_o;

  logic        w_pc, w_if, w_id, w_alu, w_we, w_ld, w_wb, w_hlt, w_flt;
  logic [1:0]  w_fc;
  logic [3:0]  w_instret;
  logic [3:0]  w_state;

  int total = 0;
  int bad   = 0;

  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_PC   = 9'b100000000;
  localparam logic [8:0] S_IF   = 9'b010000000;
  localparam logic [8:0] S_ID   = 9'b001000000;
  localparam logic [8:0] S_ALU  = 9'b000100000;
  localparam logic [8:0] S_WE   = 9'b000010000;
  localparam logic [8:0] S_LD   = 9'b000001000;
  localparam logic [8:0] S_WB   = 9'b000000100;
  localparam logic [8:0] S_HLT  = 9'b000000010;
  localparam logic [8:0] S_FLT  = 9'b000000001;

  typedef struct {
    logic       rst;
    logic       start;
    logic       rdy;
    logic [3:0] op;
    logic       wd;
    logic [3:0] st;
    logic [8:0] strb;
    logic [1:0] fc;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  candy_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .if_ready(if_ready), .op(op),
    .wb_done(wb_done), .pc_enable(pc_enable), .if_enable(if_enable),
    .id_enable(id_enable), .alu_enable(alu_enable), .reg_we(reg_we),
    .load_enable(load_enable), .wb_enable(wb_enable), .halted(halted),
    .fault(fault), .fault_code(fault_code), .instret(instret), .state_o(state_o)
  );

  candy_ctrl #(.CNT_W(4)) dut_w (
    .clk(clk), .rst(rst), .start(start), .if_ready(if_ready), .op(op),
    .wb_done(wb_done), .pc_enable(w_pc), .if_enable(w_if),
    .id_enable(w_id), .alu_enable(w_alu), .reg_we(w_we),
    .load_enable(w_ld), .wb_enable(w_wb), .halted(w_hlt),
    .fault(w_flt), .fault_code(w_fc), .instret(w_instret), .state_o(w_state)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] strobes();
    return {pc_enable, if_enable, id_enable, alu_enable, reg_we,
            load_enable, wb_enable, halted, fault};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic rdy,
                       input logic [3:0] o, input logic wd);
    rst = r; start = s; if_ready = rdy; op = o; wb_done = wd;
  endtask

  task automatic v(input logic r, input logic s, input logic rdy, input logic [3:0] o,
                   input logic wd, input logic [3:0] st, input logic [8:0] strb,
                   input logic [1:0] fc, input logic [31:0] ir);
    vec_t e;
    e.rst = r; e.start = s; e.rdy = rdy; e.op = o; e.wd = wd;
    e.st = st; e.strb = strb; e.fc = fc; e.ir = ir;
    vecs.push_back(e);
  endtask

  int n;
  int pc_pulses;
  int wb_cycles;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

    // ALU instruction (op=3) straight out of reset
    v(1,0,0, 4'd0,0,  4'd0, S_NONE, 2'b00, 0);
    v(0,1,0, 4'd0,0,  4'd1, S_IF,   2'b00, 0);
    v(0,0,1, 4'd0,0,  4'd2, S_ID,   2'b00, 0);
    v(0,0,0, 4'd3,0,  4'd3, S_NONE, 2'b00, 0);
    v(0,0,0, 4'd3,0,  4'd4, S_ALU,  2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd5, S_WE,   2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd8, S_PC,   2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd1, S_IF,   2'b00, 1);
    // Program: NOP, LOADI, STORE (wb_done 3 cycles late), HALT
    v(1,0,0, 4'd0,0,  4'd0, S_NONE, 2'b00, 0);
    v(0,1,0, 4'd0,0,  4'd1, S_IF,   2'b00, 0);
    v(0,0,1, 4'd0,0,  4'd2, S_ID,   2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd3, S_NONE, 2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd8, S_PC,   2'b00, 0);
    v(0,0,0, 4'd0,0,  4'd1, S_IF,   2'b00, 1);
    v(0,0,1, 4'd8,0,  4'd2, S_ID,   2'b00, 1);
    v(0,0,0, 4'd8,0,  4'd3, S_NONE, 2'b00, 1);
    v(0,0,0, 4'd8,0,  4'd6, S_LD,   2'b00, 1);
    v(0,0,0, 4'd0,0,  4'd8, S_PC,   2'b00, 1);
    v(0,0,0, 4'd0,0,  4'd1, S_IF,   2'b00, 2);
    v(0,0,1, 4'd9,0,  4'd2, S_ID,   2'b00, 2);
    v(0,0,0, 4'd9,0,  4'd3, S_NONE, 2'b00, 2);
    v(0,0,0, 4'd9,0,  4'd7, S_WB,   2'b00, 2);
    v(0,0,0, 4'd0,0,  4'd7, S_WB,   2'b00, 2);
    v(0,0,0, 4'd0,0,  4'd7, S_WB,   2'b00, 2);
    v(0,0,0, 4'd0,0,  4'd7, S_WB,   2'b00, 2);
    v(0,0,0, 4'd0,1,  4'd8, S_PC,   2'b00, 2);
    v(0,0,0, 4'd0,0,  4'd1, S_IF,   2'b00, 3);
    v(0,0,1, 4'd15,0, 4'd2, S_ID,   2'b00, 3);
    v(0,0,0, 4'd15,0, 4'd3, S_NONE, 2'b00, 3);
    v(0,0,0, 4'd15,0, 4'd9, S_HLT,  2'b00, 3);
    v(0,1,1, 4'd0,1,  4'd9, S_HLT,  2'b00, 3);
    v(0,0,0, 4'd0,0,  4'd9, S_HLT,  2'b00, 3);

    pc_pulses = 0;
    wb_cycles = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].rdy, vecs[i].op, vecs[i].wd);
      step();
      chk($sformatf("vec%0d state", i), 32'(state_o), 32'(vecs[i].st));
      chk($sformatf("vec%0d strobes", i), 32'(strobes()), 32'(vecs[i].strb));
      chk($sformatf("vec%0d fault_code", i), 32'(fault_code), 32'(vecs[i].fc));
      chk($sformatf("vec%0d instret", i), instret, vecs[i].ir);
      if (i >= 8) begin
        if (pc_enable) pc_pulses++;
        if (wb_enable) wb_cycles++;
      end
    end
    chk("program pc pulses", 32'(pc_pulses), 32'd3);
    chk("program wb cycles", 32'(wb_cycles), 32'd4);

    // Fetch timeout: if_ready never arrives
    drive(1, 0, 0, 4'd0, 0); step();
    drive(0, 1, 0, 4'd0, 0); step();
    start = 1'b0;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (state_o == 4'd1) n++;
      else break;
    end
    chk("fetch timeout cycles", 32'(n), 32'd16);
    chk("fetch timeout state", 32'(state_o), 32'd10);
    chk("fetch timeout fault", 32'(fault), 32'd1);
    chk("fetch timeout code", 32'(fault_code), 32'd1);

    // if_ready on the 16th FETCH cycle wins over timeout
    drive(1, 0, 0, 4'd0, 0); step();
    drive(0, 1, 0, 4'd0, 0); step();
    start = 1'b0;
    for (int k = 0; k < 15; k++) step();
    chk("late ready still fetch", 32'(state_o), 32'd1);
    if_ready = 1'b1; step();
    chk("late ready decode", 32'(state_o), 32'd2);
    chk("late ready no fault", 32'(fault), 32'd0);

    // Illegal opcode, then start pulses ignored
    if_ready = 1'b0; op = 4'd12; step();
    chk("illegal dispatch", 32'(state_o), 32'd3);
    step();
    chk("illegal state", 32'(state_o), 32'd10);
    chk("illegal code", 32'(fault_code), 32'd3);
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; step();
      start = 1'b0; step();
    end
    chk("fault sticky state", 32'(state_o), 32'd10);
    chk("fault sticky strobes", 32'(strobes()), 32'(S_FLT));
    chk("fault sticky code", 32'(fault_code), 32'd3);
    chk("fault instret", instret, 32'd0);

    // Reset in the middle of a STORE wait
    drive(1, 0, 0, 4'd0, 0); step();
    drive(0, 1, 1, 4'd0, 0); step();
    start = 1'b0; step(); step(); step(); step();
    chk("pre-store instret", instret, 32'd1);
    op = 4'd9; step(); step(); step();
    if_ready = 1'b0;
    chk("store entered", 32'(state_o), 32'd7);
    chk("store wb_enable", 32'(wb_enable), 32'd1);
    rst = 1'b1; step();
    chk("mid-store rst state", 32'(state_o), 32'd0);
    chk("mid-store rst wb_enable", 32'(wb_enable), 32'd0);
    chk("mid-store rst instret", instret, 32'd0);
    rst = 1'b0; start = 1'b1; step();
    chk("restart fetch", 32'(state_o), 32'd1);
    chk("restart if_enable", 32'(if_enable), 32'd1);

    // 16 NOPs with start held high: 4-bit counter wraps, 32-bit keeps going
    drive(1, 0, 0, 4'd0, 0); step();
    drive(0, 1, 0, 4'd0, 0); step();
    for (int k = 0; k < 16; k++) begin
      if_ready = 1'b1; step();
      if_ready = 1'b0; step();
      op = 4'd0; step();
      step();
      if (k == 14) chk("wrap instret 15", 32'(w_instret), 32'd15);
    end
    chk("wrap narrow instret", 32'(w_instret), 32'd0);
    chk("wrap wide instret", instret, 32'd16);
    chk("wrap state", 32'(state_o), 32'd1);
    chk("wrap narrow state", 32'(w_state), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
